cond_exec_unit: RTL

Parametrised conditional-execution unit for the ARM-style single-cycle/multicycle CPU control path. Holds the NZCV flag register and gates RegWrite/MemWrite/PCSrc/flag writes by the condition code. It also adds an If-Then (IT) block sequencer of up to MAX_IT instructions, with stall and flush support. It sits between the main decoder and the datapath write enables.

---
 rtl/cond_pkg.sv | 43 ++++
 rtl/cond_eval.sv | 45 ++++
 rtl/cond_exec_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// Shared types and helpers for the conditional-execution unit:
// ARM condition codes, IT sequencer states and NZCV bit positions.
package cond_pkg;

  // ARM condition field encodings; NV is treated as always-pass.
  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  // IT block sequencer states.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } it_state_t;

  // Bit positions inside the NZCV flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Condition used by one IT slot: the base condition, with its LSB
  // inverted for an "else" slot (then_bit = 0).
  function automatic logic [3:0] it_cond(input logic [3:0] base, input logic then_bit);
    return {base[3:1], base[0] ^ ~then_bit};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator: decides whether a 4-bit
// condition code passes against the current NZCV flags.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = flags_i[FLAG_N];
  assign z_s = flags_i[FLAG_Z];
  assign c_s = flags_i[FLAG_C];
  assign v_s = flags_i[FLAG_V];

  // Decode the condition code into a pass/fail decision.
  always_comb begin
    pass_o = 1'b1;
    case (cond_e'(cond_i))
      EQ:      pass_o = z_s;
      NE:      pass_o = ~z_s;
      CS:      pass_o = c_s;
      CC:      pass_o = ~c_s;
      MI:      pass_o = n_s;
      PL:      pass_o = ~n_s;
      VS:      pass_o = v_s;
      VC:      pass_o = ~v_s;
      HI:      pass_o = c_s & ~z_s;
      LS:      pass_o = ~c_s | z_s;
      GE:      pass_o = (n_s == v_s);
      LT:      pass_o = (n_s != v_s);
      GT:      pass_o = ~z_s & (n_s == v_s);
      LE:      pass_o = z_s | (n_s != v_s);
      AL:      pass_o = 1'b1;
      NV:      pass_o = 1'b1;
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Conditional-execution unit: holds NZCV, gates the decoder write
// enables by the effective condition and sequences IT blocks of up to
// MAX_IT instructions with stall and flush support.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int MAX_IT = 4,
  parameter int CNT_W  = $clog2(MAX_IT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Valid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              ITStart,
  input  logic [3:0]        ITBase,
  input  logic [CNT_W-1:0]  ITCount,
  input  logic [MAX_IT-1:0] ITThen,
  output logic              CondEx,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic [3:0]        Flags,
  output logic              InIT,
  output logic              ITErr
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  it_state_t         state_q, state_d;
  logic [3:0]        base_q, base_d;
  logic [MAX_IT-1:0] then_q, then_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [3:0]        flags_q, flags_d;

  logic              fire_s;
  logic              active_s;
  logic              then_ok_s;
  logic              it_legal_s;
  logic              it_err_s;
  logic [MAX_IT-1:0] then_sh_s;
  logic [3:0]        eff_cond_s;
  logic              pass_s;
  logic              issue_s;

  // An instruction only takes effect when presented, not held and not aborted.
  assign fire_s   = Valid & ~Stall & ~Flush;
  assign active_s = (state_q == ACTIVE);
  // issue_s marks cycles where the outputs are allowed to be non-zero at all.
  assign issue_s  = Valid & ~Stall & ~Flush;

  // An AL-based IT block cannot contain "else" slots: every covered
  // slot must have its then-bit set.
  always_comb begin
    then_ok_s = 1'b1;
    for (int i = 0; i < MAX_IT; i++) begin
      if ((i < int'(ITCount)) && !ITThen[i]) begin
        then_ok_s = 1'b0;
      end else begin
        then_ok_s = then_ok_s;
      end
    end
  end

  // A new IT block is accepted only from IDLE with a sane count and base.
  assign it_legal_s = !active_s
                    && (ITCount != CNT_ZERO)
                    && (int'(ITCount) <= MAX_IT)
                    && (ITBase != 4'b1111)
                    && ((ITBase != 4'b1110) || then_ok_s);
  assign it_err_s   = ITStart & ~it_legal_s;

  // Select the then/else bit of the current slot.
  assign then_sh_s = then_q >> idx_q;

  // Effective condition: slot condition inside a block, the IT
  // instruction itself is unconditional, otherwise the own Cond field.
  always_comb begin
    eff_cond_s = Cond;
    if (active_s) begin
      eff_cond_s = it_cond(base_q, then_sh_s[0]);
    end else if (ITStart) begin
      eff_cond_s = 4'b1110;
    end else begin
      eff_cond_s = Cond;
    end
  end

  cond_eval u_cond_eval (
    .cond_i  (eff_cond_s),
    .flags_i (flags_q),
    .pass_o  (pass_s)
  );

  // Illegal IT requests are squashed along with everything else gated here.
  assign CondEx   = issue_s & pass_s & ~it_err_s;
  assign PCSrc    = PCS  & CondEx;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;
  assign ITErr    = issue_s & it_err_s;
  assign Flags    = flags_q;
  assign InIT     = active_s;

  // Next-state logic for the flag register and the IT sequencer.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    then_d  = then_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    flags_d = flags_q;
    if (Flush) begin
      state_d = IDLE;
      idx_d   = CNT_ZERO;
      rem_d   = CNT_ZERO;
    end else if (fire_s && !it_err_s) begin
      if (CondEx && FlagW[1]) begin
        flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
      end else begin
        flags_d[FLAG_N:FLAG_Z] = flags_q[FLAG_N:FLAG_Z];
      end
      if (CondEx && FlagW[0]) begin
        flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
      end else begin
        flags_d[FLAG_C:FLAG_V] = flags_q[FLAG_C:FLAG_V];
      end
      case (state_q)
        IDLE: begin
          if (ITStart) begin
            state_d = ACTIVE;
            base_d  = ITBase;
            then_d  = ITThen;
            idx_d   = CNT_ZERO;
            rem_d   = ITCount;
          end else begin
            state_d = IDLE;
          end
        end
        ACTIVE: begin
          // Leave on the last slot, or early when a taken branch
          // jumps out while slots are still pending.
          if ((rem_q == CNT_ONE) || (PCSrc && (rem_q > CNT_ONE))) begin
            state_d = IDLE;
            idx_d   = CNT_ZERO;
            rem_d   = CNT_ZERO;
          end else begin
            idx_d = idx_q + CNT_ONE;
            rem_d = rem_q - CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = CNT_ZERO;
          rem_d   = CNT_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= 4'b0000;
      then_q  <= {MAX_IT{1'b0}};
      idx_q   <= CNT_ZERO;
      rem_q   <= CNT_ZERO;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      then_q  <= then_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      flags_q <= flags_d;
    end
  end

endmodule
